// File: rtl/r_burst_controller.sv
// r_burst_controller: read-side burst sequencer moving FIFO words into the downstream data register
//   clk, rst            clock and asynchronous active-high reset
//   read_en, burst_len  start request and word count (0 means 1), sampled in IDLE
//   abort               cancel the current burst
//   empty               FIFO status flag
//   ready               consumer accepts the presented word
//   rd_addr, ld, pop    memory read address, register load strobe, entry-removed strobe
//   valid, last, busy   presented-word qualifiers and activity flag
//   underflow           one-cycle pulse when a request meets an empty FIFO
module r_burst_controller #(
  parameter int ADDR_W  = 4,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               abort,
  input  logic               empty,
  input  logic               ready,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               ld,
  output logic               pop,
  output logic               valid,
  output logic               last,
  output logic               busy,
  output logic               underflow
);
  typedef enum logic [1:0] {IDLE, READ, HOLD, WAIT} state_t;
  state_t state, nxt;
  logic [BURST_W-1:0] remaining;
  logic start, cancel;
  assign start  = state == IDLE && read_en && !empty;
  assign cancel = state != IDLE && abort;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? READ : IDLE;
      READ:    nxt = HOLD;
      HOLD:    nxt = !ready ? HOLD : (remaining == '0) ? IDLE : empty ? WAIT : READ;
      WAIT:    nxt = empty ? WAIT : READ;
      default: nxt = IDLE;
    endcase
    if (cancel) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= nxt;
      underflow <= state == IDLE && read_en && empty;
      // the pop in READ always completes, even when the burst is being aborted
      if (state == READ) rd_addr <= rd_addr + ADDR_W'(1);
      if (cancel) remaining <= '0;
      else if (state == READ) remaining <= remaining - BURST_W'(1);
      else if (start) remaining <= (burst_len == '0) ? BURST_W'(1) : burst_len;
    end
  end
  assign ld    = state == READ;
  assign pop   = ld;
  assign valid = state == HOLD;
  assign last  = valid && remaining == '0;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_r_burst_controller.sv
// tb_r_burst_controller: scoreboard bench for r_burst_controller with a FIFO and data-register model
module tb_r_burst_controller;
  localparam int AW = 4;
  localparam int BW = 4;
  logic clk = 0, rst = 0, read_en = 0, abort = 0, ready = 0, push = 0;
  logic [BW-1:0] burst_len = '0;
  logic [7:0] push_data = '0;
  logic [AW-1:0] rd_addr;
  logic ld, pop, valid, last, busy, underflow, empty;
  always #5 clk = ~clk;
  r_burst_controller #(.ADDR_W(AW), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .burst_len(burst_len), .abort(abort),
    .empty(empty), .ready(ready), .rd_addr(rd_addr), .ld(ld), .pop(pop),
    .valid(valid), .last(last), .busy(busy), .underflow(underflow)
  );
  logic [7:0] mem_m [16];
  logic [AW-1:0] wptr;
  int cnt;
  assign empty = cnt == 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      cnt  <= 0;
    end else begin
      if (push) begin
        mem_m[wptr] <= push_data;
        wptr <= wptr + 1'b1;
      end
      cnt <= cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  end
  logic [7:0] dreg;
  logic [AW-1:0] daddr;
  always @(posedge clk) if (ld) begin
    dreg  <= mem_m[rd_addr];
    daddr <= rd_addr;
  end
  typedef struct {logic [AW-1:0] addr; logic last;} exp_t;
  exp_t exp_q[$];
  int passed = 0, total = 0, pop_cnt = 0;
  logic [AW-1:0] exp_rd = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (pop) pop_cnt++;
    if (valid && ready && !abort) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected word addr=%0h last=%b", daddr, last);
      else begin
        e = exp_q.pop_front();
        if (daddr !== e.addr || last !== e.last || dreg !== mem_m[e.addr])
          $display("FAIL sb_word got addr=%0h last=%b data=%0h exp addr=%0h last=%b data=%0h",
                   daddr, last, dreg, e.addr, e.last, mem_m[e.addr]);
        else passed++;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(int n);
    for (int i = 0; i < n; i++) begin
      push = 1;
      push_data = 8'($urandom);
      step();
    end
    push = 0;
  endtask
  task automatic enqueue(int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{AW'(int'(exp_rd) + k), k == n - 1});
  endtask
  task automatic run_burst(int len, int n, int sw, int sc);
    int w = 0, st = 0;
    logic [AW-1:0] ha = '0;
    pop_cnt = 0;
    enqueue(n);
    read_en = 1;
    burst_len = BW'(len);
    ready = 1;
    step();
    read_en = 0;
    for (int c = 0; c < 80 && busy; c++) begin
      if (valid) begin
        if (w == sw && st < sc) begin
          if (st > 0) begin
            total++;
            if (rd_addr !== ha || last !== 1'b0 || ld !== 1'b0)
              $display("FAIL stall_hold got addr=%0h last=%b ld=%b exp addr=%0h last=0 ld=0", rd_addr, last, ld, ha);
            else passed++;
          end
          ha = rd_addr;
          ready = 0;
          st++;
        end else begin
          ready = 1;
          w++;
        end
      end
      step();
    end
    ready = 1;
    total++;
    if (busy !== 1'b0 || pop_cnt != n || exp_q.size() != 0)
      $display("FAIL burst_end got busy=%b pops=%0d pending=%0d exp busy=0 pops=%0d pending=0", busy, pop_cnt, exp_q.size(), n);
    else passed++;
    exp_rd = exp_rd + AW'(n);
    total++;
    if (rd_addr !== exp_rd) $display("FAIL burst_addr got %0h exp %0h", rd_addr, exp_rd);
    else passed++;
  endtask
  task automatic test_reset();
    #1 rst = 1;
    #2;
    total++;
    if ({rd_addr, ld, pop, valid, last, busy, underflow} !== '0)
      $display("FAIL reset_async got addr=%0h ld=%b valid=%b busy=%b uf=%b exp all 0", rd_addr, ld, valid, busy, underflow);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step();
    total++;
    if ({rd_addr, ld, pop, valid, last, busy, underflow} !== '0)
      $display("FAIL reset_idle got addr=%0h ld=%b valid=%b busy=%b uf=%b exp all 0", rd_addr, ld, valid, busy, underflow);
    else passed++;
  endtask
  task automatic test_single();
    fill(3);
    enqueue(1);
    pop_cnt = 0;
    ready = 1;
    read_en = 1;
    burst_len = 1;
    step();
    read_en = 0;
    total++;
    if (ld !== 1'b1 || pop !== 1'b1 || valid !== 1'b0 || rd_addr !== exp_rd)
      $display("FAIL single_ld got ld=%b pop=%b valid=%b addr=%0h exp 1 1 0 %0h", ld, pop, valid, rd_addr, exp_rd);
    else passed++;
    step();
    total++;
    if (valid !== 1'b1 || last !== 1'b1 || ld !== 1'b0 || rd_addr !== exp_rd + 1'b1)
      $display("FAIL single_valid got valid=%b last=%b ld=%b addr=%0h exp 1 1 0 %0h", valid, last, ld, rd_addr, exp_rd + 1'b1);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0 || pop_cnt != 1 || exp_q.size() != 0)
      $display("FAIL single_done got busy=%b pops=%0d pending=%0d exp 0 1 0", busy, pop_cnt, exp_q.size());
    else passed++;
    exp_rd = exp_rd + 1'b1;
  endtask
  task automatic test_backpressure();
    fill(4);
    run_burst(4, 4, 1, 3);
  endtask
  task automatic test_len0();
    run_burst(0, 1, -1, 0);
    run_burst(1, 1, -1, 0);
  endtask
  task automatic test_underflow_stall();
    read_en = 1;
    burst_len = 2;
    step();
    read_en = 0;
    total++;
    if (underflow !== 1'b1 || busy !== 1'b0 || ld !== 1'b0)
      $display("FAIL underflow_pulse got uf=%b busy=%b ld=%b exp 1 0 0", underflow, busy, ld);
    else passed++;
    step();
    total++;
    if (underflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL underflow_clear got uf=%b busy=%b exp 0 0", underflow, busy);
    else passed++;
    fill(1);
    enqueue(3);
    pop_cnt = 0;
    ready = 1;
    read_en = 1;
    burst_len = 3;
    step();
    read_en = 0;
    step();
    step();
    total++;
    if (busy !== 1'b1 || valid !== 1'b0 || ld !== 1'b0)
      $display("FAIL wait_enter got busy=%b valid=%b ld=%b exp 1 0 0", busy, valid, ld);
    else passed++;
    read_en = 1;
    step();
    read_en = 0;
    total++;
    if (underflow !== 1'b0 || valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL wait_hold got uf=%b valid=%b busy=%b exp 0 0 1", underflow, valid, busy);
    else passed++;
    fill(2);
    for (int c = 0; c < 40 && busy; c++) step();
    total++;
    if (busy !== 1'b0 || pop_cnt != 3 || exp_q.size() != 0 || rd_addr !== exp_rd + 2'd3)
      $display("FAIL wait_resume got busy=%b pops=%0d pending=%0d addr=%0h exp 0 3 0 %0h", busy, pop_cnt, exp_q.size(), rd_addr, exp_rd + 2'd3);
    else passed++;
    exp_rd = exp_rd + 2'd3;
  endtask
  task automatic test_wrap();
    fill(4);
    run_burst(4, 4, -1, 0);
    fill(4);
    run_burst(4, 4, -1, 0);
  endtask
  task automatic test_abort();
    logic [AW-1:0] b = exp_rd;
    fill(5);
    exp_q.push_back('{b, 1'b0});
    pop_cnt = 0;
    ready = 1;
    read_en = 1;
    burst_len = 5;
    step();
    read_en = 0;
    step();
    step();
    step();
    total++;
    if (valid !== 1'b1 || last !== 1'b0)
      $display("FAIL abort_pre got valid=%b last=%b exp 1 0", valid, last);
    else passed++;
    abort = 1;
    step();
    abort = 0;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || rd_addr !== b + 2'd2 || pop_cnt != 2 || exp_q.size() != 0)
      $display("FAIL abort_idle got busy=%b valid=%b addr=%0h pops=%0d pending=%0d exp 0 0 %0h 2 0", busy, valid, rd_addr, pop_cnt, exp_q.size(), b + 2'd2);
    else passed++;
    exp_rd = b + 2'd2;
  endtask
  task automatic test_reset_mid();
    ready = 0;
    read_en = 1;
    burst_len = 3;
    step();
    read_en = 0;
    step();
    total++;
    if (valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL rstmid_pre got valid=%b busy=%b exp 1 1", valid, busy);
    else passed++;
    #2 rst = 1;
    #1;
    total++;
    if ({rd_addr, ld, pop, valid, last, busy, underflow} !== '0)
      $display("FAIL rstmid_async got addr=%0h ld=%b valid=%b busy=%b exp all 0", rd_addr, ld, valid, busy);
    else passed++;
    exp_q.delete();
    #3 rst = 0;
    exp_rd = '0;
    step();
    fill(2);
    run_burst(2, 2, -1, 0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_len0();
    test_underflow_stall();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/r_burst_controller.md
Name: r_burst_controller

Overview:
Parametrised read-side controller for the synchronous FIFO. It owns the read pointer and sequences single or burst reads from FIFO memory into the downstream data register. Each word is presented with a valid/ready handshake, and the controller stalls cleanly when the FIFO runs dry mid-burst. It sits between the FIFO status logic (empty) and the consumer, replacing the fixed single-word read controller.

Parameters:
ADDR_W, 4, read pointer width; FIFO depth = 2**ADDR_W
BURST_W, 4, width of burst_len; maximum burst = 2**BURST_W - 1 words

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
read_en  input  1  start request, sampled only in IDLE
burst_len  input  BURST_W  words to read, sampled with an accepted read_en; 0 is treated as 1
abort  input  1  synchronous cancel of the current burst
empty  input  1  FIFO empty flag from status logic; reflects pops of previous cycles
ready  input  1  consumer accepts the presented word
rd_addr  output  ADDR_W  memory read address (current read pointer)
ld  output  1  load downstream data register from mem[rd_addr]
pop  output  1  one entry removed; to status logic; identical to ld
valid  output  1  downstream data register holds an unconsumed word
last  output  1  presented word is the final word of the burst (qualified by valid)
busy  output  1  state != IDLE
underflow  output  1  one-cycle registered pulse: read_en arrived while empty in IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rd_addr=0, remaining=0, underflow=0.
  - All outputs 0 while rst is high and after release until the next request.
- State register: IDLE, READ, HOLD, WAIT. Outputs are Moore-decoded from state and registers; no input-to-output combinational path.
- IDLE:
  - read_en=1 and empty=0 -> READ; remaining <= (burst_len==0 ? 1 : burst_len).
  - read_en=1 and empty=1 -> stay IDLE; underflow=1 on the next cycle only.
  - Otherwise stay IDLE.
- READ:
  - ld=pop=1 for exactly one cycle.
  - At the edge: rd_addr <= rd_addr+1, wrapping modulo 2**ADDR_W (e.g. 4'hF -> 4'h0); remaining <= remaining-1.
  - Always -> HOLD.
- HOLD:
  - valid=1; last=(remaining==0).
  - ready=0 -> stay HOLD; data and last held stable.
  - ready=1 and remaining==0 -> IDLE.
  - ready=1, remaining!=0, empty=0 -> READ. Sustained throughput is one word per 2 cycles.
  - ready=1, remaining!=0, empty=1 -> WAIT.
- WAIT: valid=0. empty=0 -> READ; otherwise stay WAIT.
- abort=1 in any non-IDLE state -> IDLE next cycle; remaining <= 0; rd_addr keeps its value.
  - abort in READ: the pop still completes.
  - abort in HOLD: the word is dropped whether or not ready is high.
  - abort has priority over all other transitions.
- Latency: read_en accepted at edge n -> ld/pop during cycle n+1 -> valid from cycle n+2.
- read_en in any non-IDLE state is ignored, with no underflow pulse.
- Full-FIFO reads need no special case; reading from a full FIFO is legal.
- rd_addr only changes in READ and never more than once per pop.
- Re-asserting rst mid-burst returns immediately to the reset values.

Test Plan:
- Single read: FIFO holds 3 words, burst_len=1, ready=1, read_en pulse at cycle 0 -> ld/pop at cycle 1, valid=last=1 at cycle 2, rd_addr 0->1, IDLE at cycle 3.
- Burst with backpressure: burst_len=4, 6 words stored, ready low for 3 cycles on word 2 -> exactly 4 pops, addresses 0..3, word 2 held stable for 3 cycles, last only on word 4.
- Underflow and stall: read_en with empty=1 -> underflow pulse 1 cycle later, no pop. Then burst_len=3 with 1 word stored -> WAIT after word 1 with valid=0; push 2 words -> resumes, 3 pops total.
- Wrap: preload rd_addr to 14 via prior reads, burst_len=4 -> addresses 14,15,0,1.
- burst_len=0 -> behaves as 1 (one pop, last=1). abort asserted in HOLD of a 5-word burst after word 2 -> IDLE next cycle, rd_addr=2, valid=0.
- Async reset asserted in HOLD mid-burst -> valid, busy, ld, rd_addr all 0 without a clock edge. After release, read_en starts a fresh burst from address 0.
